ppu_sym_pad: RTL and testbench
==============================

Name: ppu_sym_pad

Overview:
Parametrised payload padding unit for the OFDM transmit chain. It sits between the payload encoder/interleaver input and the symbol mapper. It passes a bit-serial coded payload of run-time length through, then appends padding bits so the total is an integer number of OFDM symbols. Padding is either a cyclic repeat of the first payload bits or zeros, chosen at run time. It also reports the resulting symbol count.

Parameters:
CBPS, 1920, coded bits per OFDM symbol; buffer depth; must be >= 2.
LEN_W, 16, width of payload length input (max payload 2^LEN_W-1 bits).
SYM_W, 8, width of symbol-count output; must hold ceil((2^LEN_W-1)/CBPS).

Ports:
clk  in  1  working clock
rst  in  1  reset
start  in  1  one-cycle pulse; latches len and pad_mode, arms block
len  in  LEN_W  payload length in bits, sampled on start
pad_mode  in  1  0 = repeat payload head, 1 = zero padding; sampled on start
di  in  1  payload bit
di_vld  in  1  payload bit valid; gaps allowed
do  out  1  output bit
do_vld  out  1  output valid
do_last  out  1  marks final output bit of the frame
do_sym_num  out  SYM_W  symbols in frame; updated with do_last
busy  out  1  high from accepted start until cycle after do_last
err  out  1  sticky protocol error; cleared by next accepted start

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset all outputs = 0, FSM = IDLE, all counters = 0. Buffer contents need not be cleared.
- FSM states are IDLE, LOAD, PAD.
- IDLE:
  - start with len > 0 -> LOAD; busy = 1 next cycle.
  - start with len = 0 -> stay IDLE; one-cycle do_last with do_vld = 0, do_sym_num = 0.
  - di_vld in IDLE -> bit dropped, err = 1.
- LOAD:
  - Each di_vld bit k (0-based) appears on do with do_vld = 1 exactly 1 cycle later. Gaps in di_vld propagate as gaps in do_vld.
  - Bits with k < min(len, CBPS) are written to internal buffer address k.
  - Phase counter counts modulo CBPS; symbol counter increments on each wrap and on a non-zero final phase.
  - On bit k = len-1 the block computes pad = (phase == 0) ? 0 : CBPS - phase, with phase taken after the bit.
  - pad = 0 -> do_last is asserted with that final payload bit; go to IDLE.
  - Otherwise go to PAD.
- PAD:
  - Emits pad bits with do_vld = 1 every cycle, contiguous. The first pad bit is on the cycle after the last payload output.
  - Pad bit j = buffer[j mod min(len, CBPS)] when pad_mode = 0; = 0 when pad_mode = 1.
  - do_last is on pad bit pad-1, then go to IDLE.
  - di_vld during PAD -> bit dropped, err = 1.
- do_sym_num = ceil(len/CBPS), updated in the do_last cycle and held until the next do_last.
- busy deasserts the cycle after do_last.
- start while busy -> ignored, err = 1; the current frame is unaffected.
- start and di_vld in the same IDLE cycle -> start accepted and that di bit is payload bit 0.
- Total output bits per frame = do_sym_num * CBPS.
- Reset mid-frame: immediate abort, all outputs 0, FSM to IDLE; the partial frame is discarded and no do_last is issued.
- Width rules:
  - Counters are LEN_W wide; buffer index is clog2(CBPS) wide.
  - The mod-min(len, CBPS) wrap is implemented as an up-counter reset at the limit, not a divider.
  - No backpressure: the downstream mapper always accepts.

Test Plan:
- CBPS=1920, len=8640, pad_mode=0, random di -> 9600 do_vld bits; bits 8640..9599 equal input bits 0..959; do_last on bit 9599; do_sym_num = 5; err = 0.
- CBPS=1920, len=3840 (exact fit) -> 3840 outputs, no pad, do_last on payload bit 3839, do_sym_num = 2.
- CBPS=16, len=5, di = 1,0,1,1,0, pad_mode=0 -> output 1011010110101101 (11 pad bits cyclic), do_sym_num = 1.
- CBPS=16, len=20, pad_mode=1, di_vld with random gaps -> payload gaps mirrored on do_vld; 12 contiguous zero pad bits; do_sym_num = 2.
- Protocol errors: start pulsed during LOAD, and di_vld during PAD -> err = 1, frame output unchanged; next start clears err.
- rst asserted mid-PAD -> same-cycle outputs 0, busy = 0, no do_last; a following frame with len=5 behaves as in scenario 3.

Source files
------------

// File: rtl/ppu_sym_pad.sv
// ppu_sym_pad: passes a bit-serial coded payload straight through, then appends
// cyclic-head or zero padding so every frame fills a whole number of OFDM symbols.
module ppu_sym_pad #(
  parameter int CBPS  = 1920,
  parameter int LEN_W = 16,
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             pad_mode,
  input  logic             di,
  input  logic             di_vld,
  // 'do' is a reserved word in SystemVerilog, so the output bit is do_bit
  output logic             do_bit,
  output logic             do_vld,
  output logic             do_last,
  output logic [SYM_W-1:0] do_sym_num,
  output logic             busy,
  output logic             err
);

  localparam int               IDX_W    = $clog2(CBPS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CBPS_L   = LEN_W'(CBPS);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CBPS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PAD} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] pad_rem;
  logic [IDX_W-1:0] phase;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] lim_m1;
  logic [SYM_W-1:0] sym_cnt;
  logic [SYM_W-1:0] sym_q;
  logic             mode_q;
  logic             buf_mem [CBPS];

  logic             take_start;
  logic             in_bit;
  logic             last_bit;
  logic             wr_en;
  logic             err_evt;
  logic [LEN_W-1:0] k_cur;
  logic [LEN_W-1:0] len_cur;
  logic [LEN_W-1:0] pad_calc;
  logic [IDX_W-1:0] phase_cur;
  logic [IDX_W-1:0] phase_nxt;
  logic [SYM_W-1:0] sym_nxt;
  logic [SYM_W-1:0] sym_fin;

  // A start accepted in IDLE may carry payload bit 0 in the same cycle, so the
  // per-bit bookkeeping looks at the live len and zeroed counters in that case.
  always_comb begin
    take_start = start && (state == IDLE) && !busy;
    in_bit     = di_vld && ((state == LOAD) || (take_start && (len != '0)));
    k_cur      = (state == LOAD) ? cnt   : '0;
    len_cur    = (state == LOAD) ? len_q : len;
    phase_cur  = (state == LOAD) ? phase : '0;
    last_bit   = in_bit && (k_cur == len_cur - LEN_ONE);
    phase_nxt  = (phase_cur == IDX_LAST) ? '0 : phase_cur + IDX_ONE;
    sym_nxt    = ((state == LOAD) ? sym_cnt : '0) + SYM_W'(phase_nxt == '0);
    sym_fin    = sym_nxt + SYM_W'(phase_nxt != '0);
    pad_calc   = (phase_nxt == '0) ? '0 : CBPS_L - LEN_W'(phase_nxt);
    wr_en      = in_bit && (int'(k_cur) < CBPS);
    err_evt    = (start && !take_start) || (di_vld && !in_bit);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[IDX_W'(k_cur)] <= di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      do_bit     <= 1'b0;
      do_vld     <= 1'b0;
      do_last    <= 1'b0;
      do_sym_num <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      len_q      <= '0;
      cnt        <= '0;
      pad_rem    <= '0;
      phase      <= '0;
      rd_idx     <= '0;
      lim_m1     <= '0;
      sym_cnt    <= '0;
      sym_q      <= '0;
      mode_q     <= 1'b0;
    end else begin
      do_bit  <= 1'b0;
      do_vld  <= 1'b0;
      do_last <= 1'b0;
      err     <= take_start ? err_evt : (err | err_evt);

      if (in_bit) begin
        do_bit <= di;
        do_vld <= 1'b1;
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (take_start) begin
            len_q   <= len;
            mode_q  <= pad_mode;
            cnt     <= '0;
            phase   <= '0;
            sym_cnt <= '0;
            rd_idx  <= '0;
            lim_m1  <= (int'(len) >= CBPS) ? IDX_LAST : IDX_W'(len - LEN_ONE);
            if (len == '0) begin
              do_last    <= 1'b1;
              do_sym_num <= '0;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
        end
        PAD: begin
          // The head-repeat index wraps at min(len, CBPS) by a compare, not a modulo.
          do_vld  <= 1'b1;
          do_bit  <= mode_q ? 1'b0 : buf_mem[rd_idx];
          rd_idx  <= (rd_idx == lim_m1) ? '0 : rd_idx + IDX_ONE;
          pad_rem <= pad_rem - LEN_ONE;
          if (pad_rem == LEN_ONE) begin
            do_last    <= 1'b1;
            do_sym_num <= sym_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Busy is left high through the do_last cycle and drops from IDLE next cycle.
      if (in_bit) begin
        cnt     <= k_cur + LEN_ONE;
        phase   <= phase_nxt;
        sym_cnt <= sym_nxt;
        if (last_bit) begin
          sym_q <= sym_fin;
          if (pad_calc == '0) begin
            do_last    <= 1'b1;
            do_sym_num <= sym_fin;
            state      <= IDLE;
          end else begin
            pad_rem <= pad_calc;
            state   <= PAD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_sym_pad.sv
// tb_ppu_sym_pad: scoreboard bench with a 1920-bit and a 16-bit symbol instance;
// expected bits carry the cycle they must appear in, so gaps and pad timing are checked.
module tb_ppu_sym_pad;

  localparam int CBPS_A = 1920;
  localparam int CBPS_B = 16;
  localparam int LEN_W  = 16;
  localparam int SYM_W  = 12;

  typedef struct {
    int   cyc;
    logic b;
    logic last;
    int   sym;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_s   [2];
  logic [LEN_W-1:0] len_s     [2];
  logic             mode_s    [2];
  logic             di_s      [2];
  logic             vld_in    [2];
  logic             dout_o    [2];
  logic             vld_o     [2];
  logic             do_last_o [2];
  logic [SYM_W-1:0] sym_o     [2];
  logic             busy_o    [2];
  logic             err_o     [2];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ppu_sym_pad #(.CBPS(CBPS_A), .LEN_W(LEN_W), .SYM_W(SYM_W)) dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .len(len_s[0]), .pad_mode(mode_s[0]),
    .di(di_s[0]), .di_vld(vld_in[0]), .do_bit(dout_o[0]), .do_vld(vld_o[0]),
    .do_last(do_last_o[0]), .do_sym_num(sym_o[0]), .busy(busy_o[0]), .err(err_o[0])
  );

  ppu_sym_pad #(.CBPS(CBPS_B), .LEN_W(LEN_W), .SYM_W(SYM_W)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .len(len_s[1]), .pad_mode(mode_s[1]),
    .di(di_s[1]), .di_vld(vld_in[1]), .do_bit(dout_o[1]), .do_vld(vld_o[1]),
    .do_last(do_last_o[1]), .do_sym_num(sym_o[1]), .busy(busy_o[1]), .err(err_o[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic push(input int sel, input int c, input logic b, input logic last, input int sym);
    exp_t e;
    e.cyc  = c;
    e.b    = b;
    e.last = last;
    e.sym  = sym;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic flush(input int sel);
    if (sel == 0) q_a.delete();
    else          q_b.delete();
  endtask

  task automatic monitor(input int sel);
    exp_t  e;
    string p;
    p = (sel == 0) ? "a_" : "b_";
    if (vld_o[sel] !== 1'b1) return;
    if (qsize(sel) == 0) begin
      checkOutput({p, "extra_out"}, 32'(1), 32'(0));
      return;
    end
    if (sel == 0) e = q_a.pop_front();
    else          e = q_b.pop_front();
    checkOutput({p, "bit"}, 32'(dout_o[sel]), 32'(e.b));
    checkOutput({p, "cycle"}, cyc, e.cyc);
    checkOutput({p, "last"}, 32'(do_last_o[sel]), 32'(e.last));
    if (e.last) begin
      checkOutput({p, "sym_num"}, 32'(sym_o[sel]), e.sym);
      checkOutput({p, "busy_at_last"}, 32'(busy_o[sel]), 32'(1));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitor(0);
      monitor(1);
    end
  end

  // One frame: start, payload (optional gaps / protocol errors), pad expectations, drain.
  task automatic applyStimulus(input int sel, input int n, input bit mode, input int gap_pct,
                               input int err_mode, input bit same, input bit abort,
                               input bit use_fix, input logic [31:0] fix);
    int    c, lim, pad, syms, k0, last_cyc, waited;
    bit    pay[];
    string p;
    p    = (sel == 0) ? "a_" : "b_";
    c    = (sel == 0) ? CBPS_A : CBPS_B;
    syms = (n + c - 1) / c;
    pad  = syms * c - n;
    lim  = (n < c) ? n : c;
    pay  = new[n];
    for (int i = 0; i < n; i++) begin
      if (use_fix) pay[i] = fix[i % 32];
      else         pay[i] = 1'($urandom_range(1));
    end

    start_s[sel] = 1'b1;
    len_s[sel]   = LEN_W'(n);
    mode_s[sel]  = mode;
    k0           = 0;
    last_cyc     = cyc;
    if (same) begin
      di_s[sel]   = pay[0];
      vld_in[sel] = 1'b1;
      push(sel, cyc + 1, pay[0], (n == 1) && (pad == 0), syms);
      k0 = 1;
    end
    @(posedge clk); #1;
    start_s[sel] = 1'b0;
    vld_in[sel]  = 1'b0;

    for (int k = k0; k < n; k++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        vld_in[sel]  = 1'b0;
        start_s[sel] = 1'b0;
        repeat (1 + $urandom_range(2)) begin
          @(posedge clk); #1;
        end
      end
      di_s[sel]    = pay[k];
      vld_in[sel]  = 1'b1;
      start_s[sel] = (err_mode == 1) && (k == n / 2);
      push(sel, cyc + 1, pay[k], (k == n - 1) && (pad == 0), syms);
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    vld_in[sel]  = 1'b0;
    start_s[sel] = 1'b0;

    for (int j = 0; j < pad; j++) begin
      push(sel, last_cyc + 2 + j, mode ? 1'b0 : pay[j % lim], j == pad - 1, syms);
    end

    if (err_mode == 2 && pad > 0) begin
      di_s[sel]   = 1'b1;
      vld_in[sel] = 1'b1;
      @(posedge clk); #1;
      vld_in[sel] = 1'b0;
    end

    if (abort) begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput({p, "rst_vld"},  32'(vld_o[sel]),     32'(0));
      checkOutput({p, "rst_last"}, 32'(do_last_o[sel]), 32'(0));
      checkOutput({p, "rst_bit"},  32'(dout_o[sel]),    32'(0));
      checkOutput({p, "rst_busy"}, 32'(busy_o[sel]),    32'(0));
      checkOutput({p, "rst_sym"},  32'(sym_o[sel]),     32'(0));
      flush(sel);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end

    waited = 0;
    while (qsize(sel) != 0 && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    checkOutput({p, "drain"}, 32'(qsize(sel)), 32'(0));
    flush(sel);
    #1;
    checkOutput({p, "busy_end"}, 32'(busy_o[sel]), 32'(0));
    checkOutput({p, "err_end"},  32'(err_o[sel]),  32'(err_mode != 0));
    checkOutput({p, "sym_hold"}, 32'(sym_o[sel]),  syms);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      len_s[i]   = '0;
      mode_s[i]  = 1'b0;
      di_s[i]    = 1'b0;
      vld_in[i]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_vld",  32'(vld_o[i]),     32'(0));
      checkOutput("reset_last", 32'(do_last_o[i]), 32'(0));
      checkOutput("reset_sym",  32'(sym_o[i]),     32'(0));
      checkOutput("reset_busy", 32'(busy_o[i]),    32'(0));
      checkOutput("reset_err",  32'(err_o[i]),     32'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] long frame with cyclic head padding");
    applyStimulus(0, 8640, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] exact two-symbol frame");
    applyStimulus(0, 3840, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] short frame 10110 on 16-bit symbols");
    applyStimulus(1, 5, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_000D);
    $display("[TB] zero padding with input gaps");
    applyStimulus(1, 20, 1'b1, 30, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] payload longer than one symbol, first bit with start");
    applyStimulus(1, 37, 1'b0, 20, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    $display("[TB] start pulsed during payload");
    applyStimulus(1, 20, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] input valid during padding");
    applyStimulus(1, 20, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] zero-length frame");
    start_s[1] = 1'b1;
    len_s[1]   = '0;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    checkOutput("zero_last", 32'(do_last_o[1]), 32'(1));
    checkOutput("zero_vld",  32'(vld_o[1]),     32'(0));
    checkOutput("zero_sym",  32'(sym_o[1]),     32'(0));
    checkOutput("zero_busy", 32'(busy_o[1]),    32'(0));
    checkOutput("zero_err",  32'(err_o[1]),     32'(0));
    @(posedge clk); #1;
    checkOutput("zero_last_drop", 32'(do_last_o[1]), 32'(0));

    $display("[TB] reset during padding, then clean frame");
    applyStimulus(1, 5, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_000D);
    applyStimulus(1, 5, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_000D);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
